// File: rtl/dm_load_unit.sv
// dm_load_unit: read-side load path for the M stage.
// Issues one word-aligned read per load request, waits for the memory/bridge
// acknowledge (or a timeout), then returns the addressed byte, halfword or
// word sign- or zero-extended. Misaligned loads raise adel without touching
// the bus; flush aborts whatever is in flight.
module dm_load_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  DMROp,
  input  logic [31:0] addr,
  input  logic        flush,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic [31:0] rdata,
  output logic        done,
  output logic        adel,
  output logic        bus_err
);

  // Load type encodings carried on DMROp.
  localparam logic [2:0] OP_LW  = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LB  = 3'd4;
  localparam logic [2:0] OP_LBU = 3'd5;

  // Last counter value before the timeout fires: TIMEOUT WAIT cycles in all.
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t      state;
  logic [2:0]  op_reg;     // load type latched at issue
  logic [1:0]  off_reg;    // byte offset within the word latched at issue
  logic [7:0]  count;      // WAIT cycles seen without an acknowledge

  logic        valid_op;
  logic        misaligned;
  logic [7:0]  lanes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;

  // Split the returned word into byte lanes so selection is a plain mux.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lanes[gi] = mem_rdata[8*gi +: 8];
    end
  endgenerate

  // Decode the request: is it a real load, and does it violate alignment.
  always_comb begin
    valid_op   = 1'b0;
    misaligned = 1'b0;
    case (DMROp)
      OP_LW: begin
        valid_op   = 1'b1;
        misaligned = (addr[1:0] != 2'b00);
      end
      OP_LH, OP_LHU: begin
        valid_op   = 1'b1;
        misaligned = addr[0];
      end
      OP_LB, OP_LBU: begin
        valid_op   = 1'b1;
        misaligned = 1'b0;
      end
      default: begin
        valid_op   = 1'b0;
        misaligned = 1'b0;
      end
    endcase
  end

  // Pick the addressed byte/halfword and extend according to the latched type.
  always_comb begin
    byte_sel = lanes[off_reg];
    half_sel = off_reg[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};
    case (op_reg)
      OP_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ext_data = {16'h0000, half_sel};
      OP_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ext_data = {24'h000000, byte_sel};
      default: ext_data = mem_rdata;
    endcase
  end

  // Control FSM with registered outputs; flush overrides every other event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_reg    <= 3'd0;
      off_reg   <= 2'd0;
      count     <= 8'd0;
      mem_rd_en <= 1'b0;
      mem_addr  <= 32'd0;
      busy      <= 1'b0;
      rdata     <= 32'd0;
      done      <= 1'b0;
      adel      <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      // Status flags are single-cycle pulses unless re-armed below.
      done    <= 1'b0;
      adel    <= 1'b0;
      bus_err <= 1'b0;
      if (flush) begin
        state     <= IDLE;
        mem_rd_en <= 1'b0;
        busy      <= 1'b0;
        count     <= 8'd0;
      end else begin
        case (state)
          IDLE: begin
            if (req && valid_op) begin
              if (misaligned) begin
                adel <= 1'b1;
              end else begin
                op_reg    <= DMROp;
                off_reg   <= addr[1:0];
                mem_rd_en <= 1'b1;
                mem_addr  <= {addr[31:2], 2'b00};
                busy      <= 1'b1;
                count     <= 8'd0;
                state     <= WAIT;
              end
            end
          end
          WAIT: begin
            if (mem_ack) begin
              rdata     <= ext_data;
              done      <= 1'b1;
              mem_rd_en <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else if (count == LIMIT) begin
              bus_err   <= 1'b1;
              mem_rd_en <= 1'b0;
              busy      <= 1'b0;
              count     <= 8'd0;
              state     <= IDLE;
            end else begin
              count <= count + 8'd1;
            end
          end
          default: begin
            state     <= IDLE;
            mem_rd_en <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/dm_load_unit.md
Name: dm_load_unit

Overview:
- Read-side counterpart of the store byte-enable path in the P7 MIPS CPU.
- Accepts a load request from the M stage and issues one word-aligned read on the data-memory/bridge port.
- Waits for the acknowledge, then extracts and sign- or zero-extends the addressed byte, halfword or word.
- Raises a stall while a load is in flight, and reports misaligned-address (AdEL) and bus-timeout errors to the CP0 exception logic.

Parameters:
- TIMEOUT, 16: number of WAIT cycles without mem_ack before bus_err is raised (valid range 2..255).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  1  load request, sampled in IDLE only
- DMROp  in  3  load type: 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu; 0 and 6..7 mean no load
- addr  in  32  byte address of the load
- flush  in  1  abort from exception or interrupt; highest priority
- mem_rd_en  out  1  read strobe to memory/bridge
- mem_addr  out  32  word-aligned read address
- mem_rdata  in  32  read data, valid when mem_ack=1
- mem_ack  in  1  read acknowledge
- busy  out  1  stall request to the hazard unit
- rdata  out  32  extended load result
- done  out  1  one-cycle pulse; rdata valid this cycle
- adel  out  1  one-cycle pulse: misaligned lw/lh/lhu
- bus_err  out  1  one-cycle pulse: ack timeout

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE
  - mem_rd_en, done, adel, bus_err, busy = 0
  - mem_addr = 0, rdata = 0
  - timeout counter = 0
- All outputs are registered.
- States: IDLE, WAIT.
- IDLE, req=1 with a valid DMROp:
  - Misaligned (lw with addr[1:0]!=0, or lh/lhu with addr[0]=1): adel=1 next cycle, no bus access, stay in IDLE.
  - Otherwise: latch DMROp and addr[1:0]; next cycle mem_rd_en=1, mem_addr={addr[31:2],2'b00}, busy=1; go to WAIT; counter cleared.
- IDLE, req=1 with an invalid DMROp: ignored.
- WAIT:
  - mem_rd_en and mem_addr are held stable until the cycle mem_ack=1.
  - On ack: the next cycle has rdata=extended data, done=1, mem_rd_en=0, busy=0; state returns to IDLE.
  - Latency: req sampled at edge N, rd_en high from N+1. With a same-cycle ack in cycle N+1, done is high in cycle N+2.
- Timeout: the counter increments each WAIT cycle with mem_ack=0. When it reaches TIMEOUT-1 without ack, the next cycle has bus_err=1, mem_rd_en=0, busy=0, state=IDLE, and rdata is unchanged.
- flush=1:
  - In any state, the next cycle is IDLE with mem_rd_en=0, busy=0, and done/adel/bus_err all 0.
  - flush beats a coincident mem_ack, a timeout, or a new req.
- req while in WAIT is ignored; no queueing. The hazard unit must hold the instruction while busy=1.
- Extension, with b = latched offset:
  - lw: rdata = mem_rdata.
  - lb/lbu: byte = mem_rdata[8b+7:8b]; lb sign-extends bit 7, lbu zero-fills.
  - lh/lhu: half = mem_rdata[16*b[1]+15:16*b[1]]; lh sign-extends bit 15, lhu zero-fills.
- rdata holds its last value between done pulses.
- done, adel and bus_err are mutually exclusive and each lasts exactly one cycle.
- A reset asserted while in WAIT returns the unit to IDLE. Any ack arriving after the release of reset is ignored.

Test Plan:
- Byte loads: lb to addr 0x0000_0013 with mem_rdata=0x80FF_1234 and ack on the first WAIT cycle -> mem_addr=0x0000_0010, done two cycles after req, rdata=0xFFFF_FF80. Repeat with lbu -> 0x0000_0080.
- Halfword loads: lh to addr 0x0000_0102 with mem_rdata=0x9ABC_0001 and ack after 3 WAIT cycles -> busy high 4 cycles, rdata=0xFFFF_9ABC. lhu to addr 0x...0 with the same data -> 0x0000_0001.
- Misaligned: lw to addr 0x0000_0006 -> adel for 1 cycle, mem_rd_en stays 0, busy 0, rdata unchanged. lh to addr 0x...1 -> same.
- Timeout: lw with mem_ack held 0 and TIMEOUT=16 -> bus_err exactly 16 cycles after rd_en rises, then state is IDLE. A later ack is ignored with no done.
- Flush vs ack: flush and mem_ack both asserted in the same WAIT cycle -> no done, rd_en falls next cycle. A back-to-back lw in the following cycle completes normally.
- Reset: reset asserted in WAIT, checked between clock edges -> all outputs 0 immediately. After release, a stray ack produces no done, and a new lbu completes correctly.
